// File: rtl/lnrv_icb_mux.sv
// N-to-1 ICB command multiplexer with an in-order response dispatch FIFO.
// Define LNRV_ICB_MUX_RR_EN for round-robin arbitration; fixed priority otherwise.
module lnrv_icb_mux #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ICB_COUNT  = 4,
    parameter int P_OTS_COUNT  = 2
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [P_ICB_COUNT-1:0]                   mn_icb_cmd_vld,
    output logic [P_ICB_COUNT-1:0]                   mn_icb_cmd_rdy,
    input  logic [P_ICB_COUNT-1:0]                   mn_icb_cmd_write,
    input  logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]      mn_icb_cmd_addr,
    input  logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]      mn_icb_cmd_wdata,
    input  logic [(P_DATA_WIDTH/8)*P_ICB_COUNT-1:0]  mn_icb_cmd_wstrb,
    input  logic [3*P_ICB_COUNT-1:0]                 mn_icb_cmd_size,
    output logic [P_ICB_COUNT-1:0]                   mn_icb_rsp_vld,
    input  logic [P_ICB_COUNT-1:0]                   mn_icb_rsp_rdy,
    output logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]      mn_icb_rsp_rdata,
    output logic [P_ICB_COUNT-1:0]                   mn_icb_rsp_err,
    output logic                                     s_icb_cmd_vld,
    input  logic                                     s_icb_cmd_rdy,
    output logic                                     s_icb_cmd_write,
    output logic [P_ADDR_WIDTH-1:0]                  s_icb_cmd_addr,
    output logic [P_DATA_WIDTH-1:0]                  s_icb_cmd_wdata,
    output logic [P_DATA_WIDTH/8-1:0]                s_icb_cmd_wstrb,
    output logic [2:0]                               s_icb_cmd_size,
    input  logic                                     s_icb_rsp_vld,
    output logic                                     s_icb_rsp_rdy,
    input  logic [P_DATA_WIDTH-1:0]                  s_icb_rsp_rdata,
    input  logic                                     s_icb_rsp_err
);
    localparam int L_STRB_W = P_DATA_WIDTH / 8;
    localparam int L_IDX_W  = $clog2(P_ICB_COUNT);
    localparam int L_PTR_W  = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
    localparam int L_CNT_W  = $clog2(P_OTS_COUNT + 1);

    logic [P_ICB_COUNT-1:0] r_fifo [P_OTS_COUNT];
    logic [L_PTR_W-1:0]     r_wr_ptr;
    logic [L_PTR_W-1:0]     r_rd_ptr;
    logic [L_CNT_W-1:0]     r_cnt;
    logic                   r_lock;
    logic [P_ICB_COUNT-1:0] r_lock_gnt;

    logic [P_ICB_COUNT-1:0] w_arb_gnt;
    logic [P_ICB_COUNT-1:0] w_gnt;
    logic [P_ICB_COUNT-1:0] w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    function automatic logic [L_PTR_W-1:0] ptr_inc(input logic [L_PTR_W-1:0] p);
        return (p == L_PTR_W'(P_OTS_COUNT - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef LNRV_ICB_MUX_RR_EN
    logic [L_IDX_W-1:0] r_rr_ptr;
    logic [L_IDX_W-1:0] w_rr_idx;
    logic [L_IDX_W-1:0] w_gnt_idx;

    // Scan downward from the farthest offset so the requester nearest the pointer wins.
    always_comb begin
        w_arb_gnt = '0;
        w_rr_idx  = '0;
        for (int k = P_ICB_COUNT - 1; k >= 0; k--) begin
            w_rr_idx = L_IDX_W'((int'(r_rr_ptr) + k) % P_ICB_COUNT);
            if (mn_icb_cmd_vld[w_rr_idx]) begin
                w_arb_gnt           = '0;
                w_arb_gnt[w_rr_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < P_ICB_COUNT; i++) begin
            if (w_gnt[i]) w_gnt_idx = L_IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_gnt_idx == L_IDX_W'(P_ICB_COUNT - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        w_arb_gnt = '0;
        for (int k = P_ICB_COUNT - 1; k >= 0; k--) begin
            if (mn_icb_cmd_vld[k]) begin
                w_arb_gnt    = '0;
                w_arb_gnt[k] = 1'b1;
            end
        end
    end
`endif

    assign w_full  = (r_cnt == L_CNT_W'(P_OTS_COUNT));
    assign w_empty = (r_cnt == '0);
    // A full FIFO blocks commands outright, even when a pop lands in the same cycle.
    assign w_gnt   = w_full ? '0 : (r_lock ? (r_lock_gnt & mn_icb_cmd_vld) : w_arb_gnt);

    assign s_icb_cmd_vld  = |w_gnt;
    assign mn_icb_cmd_rdy = w_gnt & {P_ICB_COUNT{s_icb_cmd_rdy}};
    assign w_push         = s_icb_cmd_vld & s_icb_cmd_rdy;

    always_comb begin
        s_icb_cmd_write = 1'b0;
        s_icb_cmd_addr  = '0;
        s_icb_cmd_wdata = '0;
        s_icb_cmd_wstrb = '0;
        s_icb_cmd_size  = '0;
        for (int i = 0; i < P_ICB_COUNT; i++) begin
            if (w_gnt[i]) begin
                s_icb_cmd_write = mn_icb_cmd_write[i];
                s_icb_cmd_addr  = mn_icb_cmd_addr[i*P_ADDR_WIDTH +: P_ADDR_WIDTH];
                s_icb_cmd_wdata = mn_icb_cmd_wdata[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                s_icb_cmd_wstrb = mn_icb_cmd_wstrb[i*L_STRB_W +: L_STRB_W];
                s_icb_cmd_size  = mn_icb_cmd_size[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock     <= 1'b0;
            r_lock_gnt <= '0;
        end else begin
            r_lock     <= s_icb_cmd_vld & ~s_icb_cmd_rdy;
            r_lock_gnt <= w_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_gnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Responses go only to the master at the FIFO head; an empty FIFO ignores the slave.
    assign w_head         = w_empty ? '0 : r_fifo[r_rd_ptr];
    assign mn_icb_rsp_vld = w_head & {P_ICB_COUNT{s_icb_rsp_vld}};
    assign mn_icb_rsp_err = w_head & {P_ICB_COUNT{s_icb_rsp_err}};
    assign s_icb_rsp_rdy  = |(w_head & mn_icb_rsp_rdy);
    assign w_pop          = s_icb_rsp_vld & s_icb_rsp_rdy;

    always_comb begin
        mn_icb_rsp_rdata = '0;
        for (int i = 0; i < P_ICB_COUNT; i++) begin
            if (w_head[i]) mn_icb_rsp_rdata[i*P_DATA_WIDTH +: P_DATA_WIDTH] = s_icb_rsp_rdata;
        end
    end

endmodule

// File: tb/tb_lnrv_icb_mux.sv
// Directed bench for lnrv_icb_mux (4 masters, 2 outstanding); follows LNRV_ICB_MUX_RR_EN if defined.
module tb_lnrv_icb_mux;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef LNRV_ICB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      mn_icb_cmd_vld;
    logic [N-1:0]      mn_icb_cmd_rdy;
    logic [N-1:0]      mn_icb_cmd_write;
    logic [AW*N-1:0]   mn_icb_cmd_addr;
    logic [DW*N-1:0]   mn_icb_cmd_wdata;
    logic [DW/8*N-1:0] mn_icb_cmd_wstrb;
    logic [3*N-1:0]    mn_icb_cmd_size;
    logic [N-1:0]      mn_icb_rsp_vld;
    logic [N-1:0]      mn_icb_rsp_rdy;
    logic [DW*N-1:0]   mn_icb_rsp_rdata;
    logic [N-1:0]      mn_icb_rsp_err;
    logic              s_icb_cmd_vld;
    logic              s_icb_cmd_rdy;
    logic              s_icb_cmd_write;
    logic [AW-1:0]     s_icb_cmd_addr;
    logic [DW-1:0]     s_icb_cmd_wdata;
    logic [DW/8-1:0]   s_icb_cmd_wstrb;
    logic [2:0]        s_icb_cmd_size;
    logic              s_icb_rsp_vld;
    logic              s_icb_rsp_rdy;
    logic [DW-1:0]     s_icb_rsp_rdata;
    logic              s_icb_rsp_err;

    int errors = 0;
    int checks = 0;

    lnrv_icb_mux #(
        .P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_ICB_COUNT(N), .P_OTS_COUNT(2)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mn_icb_cmd_vld(mn_icb_cmd_vld), .mn_icb_cmd_rdy(mn_icb_cmd_rdy),
        .mn_icb_cmd_write(mn_icb_cmd_write), .mn_icb_cmd_addr(mn_icb_cmd_addr),
        .mn_icb_cmd_wdata(mn_icb_cmd_wdata), .mn_icb_cmd_wstrb(mn_icb_cmd_wstrb),
        .mn_icb_cmd_size(mn_icb_cmd_size), .mn_icb_rsp_vld(mn_icb_rsp_vld),
        .mn_icb_rsp_rdy(mn_icb_rsp_rdy), .mn_icb_rsp_rdata(mn_icb_rsp_rdata),
        .mn_icb_rsp_err(mn_icb_rsp_err),
        .s_icb_cmd_vld(s_icb_cmd_vld), .s_icb_cmd_rdy(s_icb_cmd_rdy),
        .s_icb_cmd_write(s_icb_cmd_write), .s_icb_cmd_addr(s_icb_cmd_addr),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wstrb(s_icb_cmd_wstrb),
        .s_icb_cmd_size(s_icb_cmd_size), .s_icb_rsp_vld(s_icb_rsp_vld),
        .s_icb_rsp_rdy(s_icb_rsp_rdy), .s_icb_rsp_rdata(s_icb_rsp_rdata),
        .s_icb_rsp_err(s_icb_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int prev_idx;
        reset_n          = 1'b0;
        mn_icb_cmd_vld   = '0;
        mn_icb_cmd_write = '0;
        mn_icb_cmd_addr  = {32'h400, 32'h300, 32'h200, 32'h100};
        mn_icb_cmd_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        mn_icb_cmd_wstrb = 16'hFFFF;
        mn_icb_cmd_size  = {3'd2, 3'd2, 3'd2, 3'd2};
        mn_icb_rsp_rdy   = '0;
        s_icb_cmd_rdy    = 1'b0;
        s_icb_rsp_vld    = 1'b1;
        s_icb_rsp_rdata  = 32'h0;
        s_icb_rsp_err    = 1'b0;
        step();
        step();
        #1;
        chk("reset_rsp_vld", 128'(mn_icb_rsp_vld), 128'h0);
        chk("reset_s_rsp_rdy", 128'(s_icb_rsp_rdy), 128'h0);
        chk("reset_s_cmd_vld", 128'(s_icb_cmd_vld), 128'h0);
        chk("reset_cmd_addr_zero", 128'(s_icb_cmd_addr), 128'h0);
        reset_n = 1'b1;

        // Contention: all four masters valid for 8 handshakes, slave always responding.
        step();
        mn_icb_cmd_vld = 4'b1111;
        s_icb_cmd_rdy  = 1'b1;
        s_icb_rsp_vld  = 1'b1;
        mn_icb_rsp_rdy = 4'b1111;
        prev_idx = -1;
        for (int k = 0; k < 8; k++) begin
            idx = RR ? (k % N) : 0;
            #1;
            chk($sformatf("arb_addr_%0d", k), 128'(s_icb_cmd_addr), 128'(32'h100 * (idx + 1)));
            chk($sformatf("arb_rdy_%0d", k), 128'(mn_icb_cmd_rdy), 128'(4'b0001 << idx));
            if (prev_idx < 0)
                chk("arb_rsp_empty", 128'(mn_icb_rsp_vld), 128'h0);
            else
                chk($sformatf("arb_rsp_%0d", k), 128'(mn_icb_rsp_vld), 128'(4'b0001 << prev_idx));
            prev_idx = idx;
            step();
        end
        mn_icb_cmd_vld = '0;
        step();
        s_icb_rsp_vld = 1'b1;
        #1;
        chk("arb_drained_rdy", 128'(s_icb_rsp_rdy), 128'h0);
        chk("arb_drained_vld", 128'(mn_icb_rsp_vld), 128'h0);

        // Single master write from m1.
        s_icb_rsp_vld       = 1'b0;
        mn_icb_cmd_vld      = 4'b0010;
        mn_icb_cmd_write    = 4'b0010;
        mn_icb_cmd_addr[63:32] = 32'h1000;
        mn_icb_cmd_wdata[63:32] = 32'hA5A50001;
        #1;
        chk("m1_cmd_vld", 128'(s_icb_cmd_vld), 128'h1);
        chk("m1_cmd_addr", 128'(s_icb_cmd_addr), 128'h1000);
        chk("m1_cmd_write", 128'(s_icb_cmd_write), 128'h1);
        chk("m1_cmd_wdata", 128'(s_icb_cmd_wdata), 128'hA5A50001);
        chk("m1_cmd_rdy", 128'(mn_icb_cmd_rdy), 128'b0010);
        step();
        mn_icb_cmd_vld   = '0;
        mn_icb_cmd_write = '0;
        s_icb_rsp_vld    = 1'b1;
        s_icb_rsp_rdata  = 32'hDEAD0001;
        s_icb_rsp_err    = 1'b1;
        #1;
        chk("m1_rsp_vld", 128'(mn_icb_rsp_vld), 128'b0010);
        chk("m1_rsp_rdata", 128'(mn_icb_rsp_rdata), {32'h0, 32'h0, 32'h0, 32'h0, 32'hDEAD0001, 32'h0});
        chk("m1_rsp_err", 128'(mn_icb_rsp_err), 128'b0010);
        chk("m1_s_rsp_rdy", 128'(s_icb_rsp_rdy), 128'h1);
        step();
        s_icb_rsp_vld = 1'b0;
        s_icb_rsp_err = 1'b0;

        // Lock: m2 waits on slave backpressure while m0 requests.
        s_icb_cmd_rdy  = 1'b0;
        mn_icb_cmd_vld = 4'b0100;
        #1;
        chk("lock_c0_addr", 128'(s_icb_cmd_addr), 128'h300);
        chk("lock_c0_rdy", 128'(mn_icb_cmd_rdy), 128'h0);
        step();
        mn_icb_cmd_vld = 4'b0101;
        #1;
        chk("lock_c1_addr", 128'(s_icb_cmd_addr), 128'h300);
        step();
        #1;
        chk("lock_c2_addr", 128'(s_icb_cmd_addr), 128'h300);
        step();
        s_icb_cmd_rdy = 1'b1;
        #1;
        chk("lock_hs_addr", 128'(s_icb_cmd_addr), 128'h300);
        chk("lock_hs_rdy", 128'(mn_icb_cmd_rdy), 128'b0100);
        step();
        mn_icb_cmd_vld = 4'b0001;
        #1;
        chk("lock_m0_addr", 128'(s_icb_cmd_addr), 128'h100);
        chk("lock_m0_rdy", 128'(mn_icb_cmd_rdy), 128'b0001);
        step();
        mn_icb_cmd_vld = '0;
        s_icb_rsp_vld  = 1'b1;
        #1;
        chk("lock_rsp_first", 128'(mn_icb_rsp_vld), 128'b0100);
        step();
        #1;
        chk("lock_rsp_second", 128'(mn_icb_rsp_vld), 128'b0001);
        step();
        s_icb_rsp_vld = 1'b0;

        // Outstanding limit: two accepted, third stalls until a response completes.
        mn_icb_cmd_vld = 4'b0010;
        #1;
        chk("ots_cmd1_rdy", 128'(mn_icb_cmd_rdy), 128'b0010);
        step();
        #1;
        chk("ots_cmd2_rdy", 128'(mn_icb_cmd_rdy), 128'b0010);
        step();
        #1;
        chk("ots_full_vld", 128'(s_icb_cmd_vld), 128'h0);
        chk("ots_full_rdy", 128'(mn_icb_cmd_rdy), 128'h0);
        chk("ots_full_addr", 128'(s_icb_cmd_addr), 128'h0);
        s_icb_rsp_vld = 1'b1;
        #1;
        chk("ots_full_pop_vld", 128'(s_icb_cmd_vld), 128'h0);
        chk("ots_full_pop_rsp", 128'(mn_icb_rsp_vld), 128'b0010);
        step();
        s_icb_rsp_vld = 1'b0;
        #1;
        chk("ots_cmd3_vld", 128'(s_icb_cmd_vld), 128'h1);
        chk("ots_cmd3_rdy", 128'(mn_icb_cmd_rdy), 128'b0010);
        step();
        mn_icb_cmd_vld = '0;

        // Reset pulse with two outstanding entries.
        s_icb_rsp_vld = 1'b1;
        #1;
        chk("rst_pre_rsp", 128'(mn_icb_rsp_vld), 128'b0010);
        reset_n = 1'b0;
        #1;
        chk("rst_async_rsp", 128'(mn_icb_rsp_vld), 128'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_after_rsp", 128'(mn_icb_rsp_vld), 128'h0);
        chk("rst_after_rdy", 128'(s_icb_rsp_rdy), 128'h0);
        step();
        #1;
        chk("rst_late_rsp", 128'(mn_icb_rsp_vld), 128'h0);
        s_icb_rsp_vld = 1'b0;

        // Ordering: m3 then m0; m3 stalls its response for 4 cycles.
        mn_icb_cmd_vld = 4'b1000;
        #1;
        chk("ord_m3_rdy", 128'(mn_icb_cmd_rdy), 128'b1000);
        step();
        mn_icb_cmd_vld = 4'b0001;
        #1;
        chk("ord_m0_rdy", 128'(mn_icb_cmd_rdy), 128'b0001);
        step();
        mn_icb_cmd_vld  = '0;
        s_icb_rsp_vld   = 1'b1;
        s_icb_rsp_rdata = 32'h33;
        mn_icb_rsp_rdy  = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("ord_hold_vld_%0d", k), 128'(mn_icb_rsp_vld), 128'b1000);
            chk($sformatf("ord_hold_rdy_%0d", k), 128'(s_icb_rsp_rdy), 128'h0);
            step();
        end
        mn_icb_rsp_rdy = 4'b1001;
        #1;
        chk("ord_m3_rsp_rdy", 128'(s_icb_rsp_rdy), 128'h1);
        chk("ord_m3_rdata", 128'(mn_icb_rsp_rdata), {32'h33, 32'h0, 32'h0, 32'h0});
        step();
        s_icb_rsp_rdata = 32'h44;
        #1;
        chk("ord_m0_vld", 128'(mn_icb_rsp_vld), 128'b0001);
        chk("ord_m0_rdata", 128'(mn_icb_rsp_rdata), {32'h0, 32'h0, 32'h0, 32'h44});
        step();
        #1;
        chk("ord_empty_rdy", 128'(s_icb_rsp_rdy), 128'h0);
        s_icb_rsp_vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lnrv_icb_mux.md
LNRV_ICB_MUX -- requirements
Module: lnrv_icb_mux

Interface
REQ-001 The block SHALL have parameter P_ADDR_WIDTH, default 32, address width.
REQ-002 The block SHALL have parameter P_DATA_WIDTH, default 32, data width; wstrb width is P_DATA_WIDTH/8.
REQ-003 The block SHALL have parameter P_ICB_COUNT, default 4, number of upstream masters, legal range 2..16.
REQ-004 The block SHALL have parameter P_OTS_COUNT, default 2, maximum outstanding commands, legal range 1..8.
REQ-005 The block SHALL use one clock and an asynchronous active-low reset:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
REQ-006 Each upstream master port SHALL be packed with index i at bits [i*W +: W]:
- mn_icb_cmd_vld  in  P_ICB_COUNT  command valid
- mn_icb_cmd_rdy  out  P_ICB_COUNT  command ready
- mn_icb_cmd_write  in  P_ICB_COUNT  write flag
- mn_icb_cmd_addr  in  P_ADDR_WIDTH*P_ICB_COUNT  address
- mn_icb_cmd_wdata  in  P_DATA_WIDTH*P_ICB_COUNT  write data
- mn_icb_cmd_wstrb  in  (P_DATA_WIDTH/8)*P_ICB_COUNT  byte strobes
- mn_icb_cmd_size  in  3*P_ICB_COUNT  transfer size
- mn_icb_rsp_vld  out  P_ICB_COUNT  response valid
- mn_icb_rsp_rdy  in  P_ICB_COUNT  response ready
- mn_icb_rsp_rdata  out  P_DATA_WIDTH*P_ICB_COUNT  read data
- mn_icb_rsp_err  out  P_ICB_COUNT  response error
REQ-007 The single downstream slave port SHALL be: s_icb_cmd_vld out 1; s_icb_cmd_rdy in 1; s_icb_cmd_write out 1; s_icb_cmd_addr out P_ADDR_WIDTH; s_icb_cmd_wdata out P_DATA_WIDTH; s_icb_cmd_wstrb out P_DATA_WIDTH/8; s_icb_cmd_size out 3; s_icb_rsp_vld in 1; s_icb_rsp_rdy out 1; s_icb_rsp_rdata in P_DATA_WIDTH; s_icb_rsp_err in 1.

Function
REQ-008 The block SHALL select one requesting master per cycle (the grant), forwarding its cmd fields to s_icb_cmd_*, and forward s_icb_cmd_rdy only to that master's mn_icb_cmd_rdy. All non-granted mn_icb_cmd_rdy bits SHALL be 0.
REQ-009 The block SHALL force s_icb_cmd_vld=0, all mn_icb_cmd_rdy=0, and all forwarded cmd fields to zero when no master is valid or the dispatch FIFO is full.
REQ-010 The block SHALL hold the grant while s_icb_cmd_vld=1 and s_icb_cmd_rdy=0 (lock register), re-arbitrating only after the handshake.
REQ-011 The block SHALL push the one-hot grant into a dispatch FIFO of depth P_OTS_COUNT on every cmd handshake.
REQ-012 The block SHALL route the response to the FIFO-head master only: that master's mn_icb_rsp_vld = s_icb_rsp_vld, its rdata and err pass through, and s_icb_rsp_rdy = that master's mn_icb_rsp_rdy; the other masters' outputs SHALL be 0.
REQ-013 The block SHALL pop the FIFO on rsp handshake; push and pop in the same cycle SHALL keep the count unchanged.
REQ-014 With the FIFO empty, the block SHALL drive s_icb_rsp_rdy=0 and all mn_icb_rsp_vld=0. The earliest response to a command is one cycle after its handshake.
REQ-015 With the FIFO full, the block SHALL block commands even if a pop occurs in the same cycle.
REQ-016 Responses SHALL return in command order with no reordering.

Reset
REQ-017 Asserting reset_n=0 SHALL asynchronously empty the FIFO, clear the lock, and set the priority pointer to 0.
REQ-018 After reset, all mn_icb_rsp_vld=0 and s_icb_rsp_rdy=0. Commands may be accepted in the first cycle after release.
REQ-019 A reset in the middle of an operation SHALL discard outstanding entries. Late slave responses after reset are ignored while the FIFO is empty.

Configuration
REQ-020 The block SHALL use round-robin arbitration when macro LNRV_ICB_MUX_RR_EN is defined. The pointer advances to (granted index+1) mod P_ICB_COUNT after each handshake, and the search starts at the pointer.
REQ-021 The block SHALL use fixed priority (lowest index wins) and contain no pointer register when LNRV_ICB_MUX_RR_EN is undefined.

Verification
REQ-022 Single master: m1 writes addr 0x1000 with slave rdy=1 -> s_icb_cmd_addr=0x1000 in the same cycle; the response next cycle appears only on mn_icb_rsp_vld[1].
REQ-023 Contention with RR_EN: masters 0..3 are held valid for 8 handshakes -> grant order 0,1,2,3,0,1,2,3. Without RR_EN -> all 8 grants go to master 0.
REQ-024 Lock: master 2 is granted with s_icb_cmd_rdy=0 for 3 cycles while master 0 raises vld -> the grant stays at 2 until its handshake.
REQ-025 Outstanding limit (P_OTS_COUNT=2): 2 commands are accepted with no response -> the third is stalled (cmd_rdy=0). One rsp handshake -> the next cycle accepts the third command.
REQ-026 Ordering and backpressure: m3 then m0 commands; m3 holds rsp_rdy=0 for 4 cycles -> s_icb_rsp_rdy=0 for those cycles, and m0 sees no rsp_vld until m3's response completes.
REQ-027 Reset mid-transfer: reset_n pulsed low with 2 outstanding entries -> the FIFO is empty, and a subsequent s_icb_rsp_vld=1 yields all mn_icb_rsp_vld=0.
